// File: rtl/latch_exerciser_if.sv
// Drive/observe bundle between the exerciser and a D latch with preset/clear.
// The exerciser owns d/en/prst/rst; the latch under test returns q/qb.
interface latch_exerciser_if;
   logic d;
   logic en;
   logic prst;
   logic rst;
   logic q;
   logic qb;

   modport master (
      output d,
      output en,
      output prst,
      output rst,
      input  q,
      input  qb
   );

   modport slave (
      input  d,
      input  en,
      input  prst,
      input  rst,
      output q,
      output qb
   );
endinterface

// File: rtl/latch_exerciser.sv
// Self-checking driver for a D latch with preset/clear: runs clear, preset,
// then write/hold for each of 8 pattern bits and reports pass/err_count/first_fail.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | all drives low, waiting for start
// S_CLR   | rst high for 2 cycles, check q=0/qb=1 at the end
// S_PRE   | prst high for 2 cycles, check q=1/qb=0 at the end
// S_SETUP | d = current bit, en low
// S_OPEN  | d = current bit, en high, check q follows d
// S_HOLD  | en low, d inverted, check q still holds the bit
// S_DONE  | one-cycle done pulse, pass valid
module latch_exerciser (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [7:0]           pattern,
   latch_exerciser_if.master    lat,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [3:0]           err_count,
   output logic [4:0]           first_fail
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_PRE,
      S_SETUP,
      S_OPEN,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [4:0] NO_FAIL = 5'h1F;

   state_t      state;
   state_t      state_nxt;
   logic        tmr;
   logic        tmr_nxt;
   logic [2:0]  bit_cnt;
   logic [2:0]  bit_cnt_nxt;
   logic [7:0]  sreg;
   logic [7:0]  sreg_nxt;
   logic [4:0]  chk_id;
   logic [4:0]  chk_id_nxt;

   logic        chk_en;
   logic        exp_q;
   logic        chk_fail;

   logic        d_nxt;
   logic        en_nxt;
   logic        prst_nxt;
   logic        rst_nxt;
   logic        busy_nxt;
   logic        done_nxt;
   logic        pass_nxt;
   logic [3:0]  err_nxt;
   logic [4:0]  first_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         tmr        <= 1'b0;
         bit_cnt    <= 3'd0;
         sreg       <= 8'd0;
         chk_id     <= 5'd0;
         lat.d      <= 1'b0;
         lat.en     <= 1'b0;
         lat.prst   <= 1'b0;
         lat.rst    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 4'd0;
         first_fail <= NO_FAIL;
      end else begin
         state      <= state_nxt;
         tmr        <= tmr_nxt;
         bit_cnt    <= bit_cnt_nxt;
         sreg       <= sreg_nxt;
         chk_id     <= chk_id_nxt;
         lat.d      <= d_nxt;
         lat.en     <= en_nxt;
         lat.prst   <= prst_nxt;
         lat.rst    <= rst_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         pass       <= pass_nxt;
         err_count  <= err_nxt;
         first_fail <= first_nxt;
      end
   end

   // Sequencing: 2-cycle phases use a down-counter, bits use a down-counter from 7.
   always_comb begin
      state_nxt   = state;
      tmr_nxt     = tmr;
      bit_cnt_nxt = bit_cnt;
      sreg_nxt    = sreg;
      chk_en      = 1'b0;
      exp_q       = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt   = S_CLR;
               tmr_nxt     = 1'b1;
               bit_cnt_nxt = 3'd7;
               sreg_nxt    = pattern;
            end
         end
         S_CLR: begin
            if (tmr == 1'b0) begin
               chk_en    = 1'b1;
               exp_q     = 1'b0;
               state_nxt = S_PRE;
               tmr_nxt   = 1'b1;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         S_PRE: begin
            if (tmr == 1'b0) begin
               chk_en    = 1'b1;
               exp_q     = 1'b1;
               state_nxt = S_SETUP;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         S_SETUP: begin
            state_nxt = S_OPEN;
         end
         S_OPEN: begin
            chk_en    = 1'b1;
            exp_q     = sreg[0];
            state_nxt = S_HOLD;
         end
         S_HOLD: begin
            chk_en   = 1'b1;
            exp_q    = sreg[0];
            sreg_nxt = {1'b0, sreg[7:1]};
            if (bit_cnt == 3'd0) begin
               state_nxt = S_DONE;
            end else begin
               bit_cnt_nxt = bit_cnt - 3'd1;
               state_nxt   = S_SETUP;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are registered, so they are decoded from the state being entered.
   always_comb begin
      d_nxt    = 1'b0;
      en_nxt   = 1'b0;
      prst_nxt = 1'b0;
      rst_nxt  = 1'b0;
      busy_nxt = 1'b1;
      done_nxt = 1'b0;

      case (state_nxt)
         S_IDLE: begin
            busy_nxt = 1'b0;
         end
         S_CLR: begin
            rst_nxt = 1'b1;
         end
         S_PRE: begin
            prst_nxt = 1'b1;
         end
         S_SETUP: begin
            d_nxt = sreg_nxt[0];
         end
         S_OPEN: begin
            d_nxt  = sreg_nxt[0];
            en_nxt = 1'b1;
         end
         S_HOLD: begin
            d_nxt = ~sreg_nxt[0];
         end
         S_DONE: begin
            busy_nxt = 1'b0;
            done_nxt = 1'b1;
         end
         default: begin
            busy_nxt = 1'b0;
         end
      endcase
   end

   assign chk_fail = chk_en && ((lat.q != exp_q) || (lat.qb != ~exp_q));

   always_comb begin
      err_nxt    = err_count;
      first_nxt  = first_fail;
      pass_nxt   = pass;
      chk_id_nxt = chk_id;

      if ((state == S_IDLE) && start) begin
         err_nxt    = 4'd0;
         first_nxt  = NO_FAIL;
         pass_nxt   = 1'b0;
         chk_id_nxt = 5'd0;
      end else if (chk_en) begin
         chk_id_nxt = chk_id + 5'd1;
         if (chk_fail) begin
            if (err_count != 4'hF) begin
               err_nxt = err_count + 4'd1;
            end
            if (first_fail == NO_FAIL) begin
               first_nxt = chk_id;
            end
         end
      end

      // Verdict includes the final HOLD check taken on the same edge.
      if (state_nxt == S_DONE) begin
         pass_nxt = (err_nxt == 4'd0);
      end
   end

endmodule

// File: tb/tb_latch_exerciser.sv
// Bench for latch_exerciser: behavioural latch with fault modes, run-level
// reference model, and a scoreboard checked on each done pulse.
module tb_latch_exerciser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pattern = 8'd0;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_count;
   logic [4:0] first_fail;

   int errors = 0;
   int checks = 0;

   latch_exerciser_if lif ();

   latch_exerciser dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pattern    (pattern),
      .lat        (lif.master),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .first_fail (first_fail)
   );

   always #5 clk = ~clk;

   // 0 good latch, 1 q stuck-at-0, 2 no hold (q follows d), 3 qb tied to q
   logic [1:0] mode = 2'd0;
   logic       lq;
   logic       qm;

   always @(lif.d or lif.en or lif.prst or lif.rst) begin
      if (lif.rst)       lq = 1'b0;
      else if (lif.prst) lq = 1'b1;
      else if (lif.en)   lq = lif.d;
   end

   assign qm = (mode == 2'd1) ? 1'b0 :
               (mode == 2'd2) ? (lif.rst ? 1'b0 : (lif.prst ? 1'b1 : lif.d)) : lq;
   assign lif.q  = qm;
   assign lif.qb = (mode == 2'd3) ? qm : ~qm;

   typedef struct {
      logic [7:0] pat;
      int         errs;
      logic [4:0] first;
      logic       pass;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // What the exerciser should report, from the 18 checks it is defined to make.
   function automatic exp_t predict(input logic [7:0] p, input logic [1:0] m);
      exp_t r;
      int   n;
      n = 0;
      r.pat = p;
      r.first = 5'h1F;
      for (int k = 0; k < 18; k++) begin
         logic want;
         logic aq;
         logic aqb;
         logic is_hold;
         want = (k == 0) ? 1'b0 : (k == 1) ? 1'b1 : p[(k - 2) / 2];
         is_hold = (k >= 3) && (k % 2 == 1);
         case (m)
            2'd0: begin aq = want; aqb = ~want; end
            2'd1: begin aq = 1'b0; aqb = 1'b1; end
            2'd2: begin aq = is_hold ? ~want : want; aqb = ~aq; end
            default: begin aq = want; aqb = want; end
         endcase
         if ((aq != want) || (aqb != ~want)) begin
            n++;
            if (r.first == 5'h1F) r.first = 5'(k);
         end
      end
      r.errs = (n > 15) ? 15 : n;
      r.pass = (n == 0);
      return r;
   endfunction

   int         busy_run = 0;
   int         nbits = 0;
   logic [7:0] obits = 8'd0;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run = 0;
         nbits = 0;
      end else begin
         chk("drive_ordering",
             int'((lif.prst & lif.rst) | (lif.en & (lif.prst | lif.rst))), 0);
         if (busy) busy_run++;
         if (lif.en) begin
            if (nbits < 8) obits[nbits] = lif.d;
            nbits++;
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got done=1 expected no run pending at %0t", $time);
            end else begin
               e = sb_q.pop_front();
               chk("busy_cycles", busy_run, 28);
               chk("busy_at_done", int'(busy), 0);
               chk("open_count", nbits, 8);
               chk("open_d_seq", int'(obits), int'(e.pat));
               chk("pass", int'(pass), int'(e.pass));
               chk("err_count", int'(err_count), e.errs);
               chk("first_fail", int'(first_fail), int'(e.first));
            end
            busy_run = 0;
            nbits = 0;
         end
      end
   end

   task automatic check_reset_values(input string tag);
      chk({tag, "_d"}, int'(lif.d), 0);
      chk({tag, "_en"}, int'(lif.en), 0);
      chk({tag, "_prst"}, int'(lif.prst), 0);
      chk({tag, "_rst"}, int'(lif.rst), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_pass"}, int'(pass), 0);
      chk({tag, "_err"}, int'(err_count), 0);
      chk({tag, "_first"}, int'(first_fail), 31);
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      @(negedge clk);
      while ((busy || done || sb_q.size() != 0) && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy=%0d expected idle within 100 cycles", busy);
      end
   endtask

   // Issues start at cycle 0; optionally re-pulses start in cycles 5 and 29.
   task automatic launch(input logic [7:0] p, input logic [1:0] m, input bit poke);
      wait_idle();
      mode = m;
      pattern = p;
      start = 1'b1;
      sb_q.push_back(predict(p, m));
      @(negedge clk);
      start = 1'b0;
      pattern = 8'($urandom);
      if (poke) begin
         repeat (4) @(negedge clk);
         start = 1'b1;
         pattern = ~p;
         @(negedge clk);
         start = 1'b0;
         repeat (23) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic wait_done();
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (w >= 60) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected within 60 cycles");
         sb_q.delete();
      end
   endtask

   task automatic run_one(input logic [7:0] p, input logic [1:0] m, input bit poke);
      launch(p, m, poke);
      wait_done();
   endtask

   initial begin
      logic [7:0] rp;
      logic [1:0] rm;
      #2 rst_n = 1'b0;
      #1 check_reset_values("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_one(8'hA5, 2'd0, 1'b0);
      run_one(8'hA5, 2'd1, 1'b0);
      run_one(8'h3C, 2'd2, 1'b0);
      run_one(8'hA5, 2'd3, 1'b0);
      run_one(8'h5A, 2'd0, 1'b1);

      launch(8'h96, 2'd0, 1'b0);
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1 check_reset_values("midrun");
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_one(8'hFF, 2'd0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         rp = 8'($urandom);
         rm = 2'($urandom_range(0, 3));
         run_one(rp, rm, 1'b0);
      end

      repeat (5) @(negedge clk);
      chk("pending_runs", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
